// File: rtl/mem_stage.sv
// MEM pipeline stage: multi-cycle data memory access with byte/half/word/dword lanes and W registers.
// Optional macro MEM_ALIGN_CHECK_EN flags and suppresses misaligned accesses instead of forcing alignment.
module mem_stage #(
    parameter int DATA_W  = 32,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 1,
    parameter int REG_W   = 5
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              validM,
    input  logic              RegWriteM,
    input  logic              MemToRegM,
    input  logic              MemWriteM,
    input  logic              MemReadM,
    input  logic [1:0]        sizeM,
    input  logic              signedM,
    input  logic [DATA_W-1:0] ALUOutM,
    input  logic [DATA_W-1:0] writeDataM,
    input  logic [REG_W-1:0]  WriteRegM,
    output logic              stallM,
    output logic              validW,
    output logic              RegWriteW,
    output logic              MemToRegW,
    output logic [DATA_W-1:0] ALUOutW,
    output logic [DATA_W-1:0] readDataW,
    output logic [REG_W-1:0]  WriteRegW,
    output logic              misalignW
);

    localparam int NB    = DATA_W / 8;
    localparam int OFF_W = $clog2(NB);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LATENCY - 1);

    // Byte-enable pattern of an access size, before shifting to its lane.
    function automatic logic [NB-1:0] size_be(input logic [1:0] sz);
        logic [NB-1:0] be;
        case (sz)
            2'b00:   be = NB'(8'h01);
            2'b01:   be = NB'(8'h03);
            2'b10:   be = NB'(8'h0F);
            default: be = NB'(8'hFF);
        endcase
        return be;
    endfunction

    // Trim a right-aligned load value to its size and sign/zero-extend it.
    function automatic logic [DATA_W-1:0] extend(input logic [DATA_W-1:0] v,
                                                 input logic [1:0] sz,
                                                 input logic sgn);
        logic [DATA_W-1:0] keep;
        logic              msb;
        case (sz)
            2'b00:   begin keep = DATA_W'(8'hFF);         msb = v[7];  end
            2'b01:   begin keep = DATA_W'(16'hFFFF);      msb = v[15]; end
            2'b10:   begin keep = DATA_W'(32'hFFFF_FFFF); msb = v[31]; end
            default: begin keep = {DATA_W{1'b1}};         msb = 1'b0;  end
        endcase
        return (v & keep) | ((sgn & msb) ? ~keep : {DATA_W{1'b0}});
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              valid_q, valid_d, rw_q, rw_d, m2r_q, m2r_d, mis_q, mis_d;
    logic [DATA_W-1:0] alu_q, alu_d, rd_q, rd_d;
    logic [REG_W-1:0]  wreg_q, wreg_d;

    logic              mem_op_s, store_s, load_s, last_s, mis_s;
    logic [1:0]        size_eff_s;
    logic [OFF_W-1:0]  low_mask_s, addr_lo_s, lane_s;
    logic [IDX_W-1:0]  idx_s;
    logic [NB-1:0]     be_s;
    logic [DATA_W-1:0] rd_word_s, rd_sh_s, wdata_sh_s, wmerge_s;
    logic              unused_s;

    assign mem_op_s   = validM & (MemWriteM | MemReadM);
    assign store_s    = mem_op_s & MemWriteM;
    assign load_s     = mem_op_s & MemReadM & ~MemWriteM;
    assign last_s     = (cnt_q == CNT_LAST);
    assign stallM     = rst_n & mem_op_s & ~last_s;
    // A 32-bit datapath has no dword lane, so dword accesses degrade to word.
    assign size_eff_s = ((DATA_W == 32) && (sizeM == 2'b11)) ? 2'b10 : sizeM;
    assign addr_lo_s  = ALUOutM[OFF_W-1:0];
    assign idx_s      = ALUOutM[OFF_W +: IDX_W];
    assign unused_s   = ^{ALUOutM[DATA_W-1:OFF_W+IDX_W]};

    // Address bits that must be zero for the current access size.
    always_comb begin
        case (size_eff_s)
            2'b00:   low_mask_s = OFF_W'(0);
            2'b01:   low_mask_s = OFF_W'(1);
            2'b10:   low_mask_s = OFF_W'(3);
            default: low_mask_s = OFF_W'(7);
        endcase
    end

`ifdef MEM_ALIGN_CHECK_EN
    assign mis_s  = mem_op_s & (|(addr_lo_s & low_mask_s));
    assign lane_s = addr_lo_s;
`else
    assign mis_s  = 1'b0;
    assign lane_s = addr_lo_s & ~low_mask_s;
`endif

    assign be_s       = size_be(size_eff_s) << lane_s;
    assign rd_word_s  = mem_q[idx_s];
    assign rd_sh_s    = rd_word_s >> {lane_s, 3'b000};
    assign wdata_sh_s = writeDataM << {lane_s, 3'b000};

    // Merge enabled store lanes into the current memory word.
    always_comb begin
        wmerge_s = rd_word_s;
        for (int i = 0; i < NB; i++) begin
            if (be_s[i]) begin
                wmerge_s[8*i +: 8] = wdata_sh_s[8*i +: 8];
            end else begin
                wmerge_s[8*i +: 8] = rd_word_s[8*i +: 8];
            end
        end
    end

    // Next state: count wait cycles, emit a bubble or the completed instruction.
    always_comb begin
        cnt_d   = cnt_q;
        valid_d = 1'b0;
        rw_d    = 1'b0;
        m2r_d   = 1'b0;
        mis_d   = 1'b0;
        alu_d   = alu_q;
        rd_d    = rd_q;
        wreg_d  = wreg_q;
        if (mem_op_s && !last_s) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else if (validM) begin
            cnt_d   = CNT_W'(0);
            valid_d = 1'b1;
            rw_d    = RegWriteM & ~mis_s;
            m2r_d   = MemToRegM;
            mis_d   = mis_s;
            alu_d   = ALUOutM;
            wreg_d  = WriteRegM;
            rd_d    = (load_s && !mis_s) ? extend(rd_sh_s, size_eff_s, signedM)
                                         : {DATA_W{1'b0}};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Pipeline state registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q   <= CNT_W'(0);
            valid_q <= 1'b0;
            rw_q    <= 1'b0;
            m2r_q   <= 1'b0;
            mis_q   <= 1'b0;
            alu_q   <= {DATA_W{1'b0}};
            rd_q    <= {DATA_W{1'b0}};
            wreg_q  <= {REG_W{1'b0}};
        end else begin
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            rw_q    <= rw_d;
            m2r_q   <= m2r_d;
            mis_q   <= mis_d;
            alu_q   <= alu_d;
            rd_q    <= rd_d;
            wreg_q  <= wreg_d;
        end
    end

    // Data memory is never reset; a reset edge abandons any pending store.
    always_ff @(posedge clk) begin
        if (rst_n && store_s && last_s && !mis_s) begin
            mem_q[idx_s] <= wmerge_s;
        end
    end

    assign validW    = valid_q;
    assign RegWriteW = rw_q;
    assign MemToRegW = m2r_q;
    assign misalignW = mis_q;
    assign ALUOutW   = alu_q;
    assign readDataW = rd_q;
    assign WriteRegW = wreg_q;

endmodule
